// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator front end: streamer FSM encoding
// and the frame configuration limits.
package accel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } stream_state_t;

    localparam int POS_W         = 9;
    localparam int MIN_DIM_NOPAD = 3;
    localparam int MIN_DIM_PAD   = 1;

    // Streamed dimension: a zero border adds one position on each side.
    function automatic logic [POS_W-1:0] padded_dim(input logic [7:0] dim, input logic pad);
        return pad ? {1'b0, dim} + POS_W'(2) : {1'b0, dim};
    endfunction

    function automatic logic cfg_ok(input logic [7:0] w, input logic [7:0] h, input logic pad,
                                    input int max_w, input int max_h);
        int min_dim;
        min_dim = pad ? MIN_DIM_PAD : MIN_DIM_NOPAD;
        return (int'(w) >= min_dim) && (int'(h) >= min_dim) &&
               (int'(padded_dim(w, pad)) <= max_w) && (int'(padded_dim(h, pad)) <= max_h);
    endfunction

endpackage

// File: rtl/pixel_streamer_if.sv
// Memory read port between the pixel streamer and its pixel store.
interface pixel_streamer_if #(
    parameter int ADDR_W = 14
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;

    modport master (output mem_rd_en, output mem_addr, input mem_rdata);
    modport slave  (input mem_rd_en, input mem_addr, output mem_rdata);
endinterface

// File: rtl/raster_counter.sv
// Row/column position counter walking a width x height raster, wrapping
// back to (0,0) after the last position.
module raster_counter
    import accel_pkg::*;
#(
    parameter int CNT_W = POS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] height,
    output logic [CNT_W-1:0] r,
    output logic [CNT_W-1:0] c,
    output logic             last
);
    logic col_end;
    logic row_end;

    assign col_end = (c == width - CNT_W'(1));
    assign row_end = (r == height - CNT_W'(1));
    assign last    = col_end && row_end;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r <= '0;
            c <= '0;
        end else if (advance) begin
            if (col_end) begin
                c <= '0;
                r <= row_end ? '0 : r + CNT_W'(1);
            end else begin
                c <= c + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/pixel_streamer.sv
// Streams a (optionally zero-padded) image from memory in raster order, one
// position per cycle, with window coordinates for a 3x3 collector downstream.
module pixel_streamer
    import accel_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128,
    parameter int ADDR_W       = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        stage_width,
    input  logic [7:0]        stage_height,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              pad_en,
    pixel_streamer_if.master  mem,
    output logic [7:0]        pixel_out,
    output logic              pixel_valid,
    output logic              window_valid,
    output logic [7:0]        out_row,
    output logic [7:0]        out_col,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);
    stream_state_t     state_q, state_nx;
    logic              accept, reject;
    logic [POS_W-1:0]  sw_q, sh_q, r, c, src_col;
    logic [7:0]        w_q;
    logic              pad_q;
    logic [ADDR_W-1:0] row_base_q;
    logic              last, issue, border, col_end, rd;
    logic              vld_p1, pad_p1, last_p1, win_p1;
    logic [7:0]        r_p1, c_p1;
    logic              vld_p2, win_p2, last_p2, cfg_err_q;
    logic [7:0]        pix_p2, row_p2, col_p2;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        accept   = 1'b0;
        reject   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_ok(stage_width, stage_height, pad_en, IMAGE_WIDTH, IMAGE_HEIGHT)) begin
                        accept   = 1'b1;
                        state_nx = ST_STREAM;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_STREAM: if (last) state_nx = ST_DRAIN;
            ST_DRAIN:  if (vld_p2 && last_p2) state_nx = ST_DONE;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    raster_counter #(.CNT_W(POS_W)) u_pos (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .advance (issue),
        .width   (sw_q),
        .height  (sh_q),
        .r       (r),
        .c       (c),
        .last    (last)
    );

    assign issue   = (state_q == ST_STREAM);
    assign border  = pad_q && (r == '0 || c == '0 || r == sh_q - POS_W'(1) || c == sw_q - POS_W'(1));
    assign col_end = (c == sw_q - POS_W'(1));
    assign src_col = c - {{(POS_W-1){1'b0}}, pad_q};
    assign rd      = issue && !border;

    assign mem.mem_rd_en = rd;
    assign mem.mem_addr  = rd ? row_base_q + ADDR_W'(src_col) : '0;

    // Row base walks one source row per completed streamed row; the top pad row has no source.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_q       <= '0;
            sh_q       <= '0;
            w_q        <= '0;
            pad_q      <= 1'b0;
            row_base_q <= '0;
        end else if (accept) begin
            sw_q       <= padded_dim(stage_width, pad_en);
            sh_q       <= padded_dim(stage_height, pad_en);
            w_q        <= stage_width;
            pad_q      <= pad_en;
            row_base_q <= base_addr;
        end else if (issue && col_end && !(pad_q && r == '0)) begin
            row_base_q <= row_base_q + ADDR_W'(w_q);
        end
    end

    assign win_p1 = vld_p1 && (r_p1 >= 8'd2) && (c_p1 >= 8'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            pad_p1    <= 1'b0;
            last_p1   <= 1'b0;
            r_p1      <= '0;
            c_p1      <= '0;
            vld_p2    <= 1'b0;
            pix_p2    <= '0;
            win_p2    <= 1'b0;
            row_p2    <= '0;
            col_p2    <= '0;
            last_p2   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            // p0 -> p1: position issued, read in flight
            vld_p1    <= issue;
            pad_p1    <= border;
            last_p1   <= issue && last;
            r_p1      <= r[7:0];
            c_p1      <= c[7:0];
            // p1 -> p2: read data (or pad zero) captured for the collector
            vld_p2    <= vld_p1;
            pix_p2    <= (vld_p1 && !pad_p1) ? mem.mem_rdata : 8'd0;
            win_p2    <= win_p1;
            row_p2    <= win_p1 ? r_p1 - 8'd2 : 8'd0;
            col_p2    <= win_p1 ? c_p1 - 8'd2 : 8'd0;
            last_p2   <= last_p1;
            cfg_err_q <= reject;
        end
    end

    assign pixel_out    = pix_p2;
    assign pixel_valid  = vld_p2;
    assign window_valid = win_p2;
    assign out_row      = row_p2;
    assign out_col      = col_p2;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign cfg_err      = cfg_err_q;
endmodule

// File: tb/tb_pixel_streamer.sv
// Directed bench for pixel_streamer: table of frame configurations checked
// cycle by cycle against a raster model, plus reset/restart sequences.
module tb_pixel_streamer;
    localparam int ADDR_W = 14;
    localparam int NV     = 15;

    typedef struct {
        logic [7:0]        w;
        logic [7:0]        h;
        logic              pad;
        logic [ADDR_W-1:0] base;
        logic              err;
        int                rd;
        int                zero;
        int                win;
        int                rst_at;
        int                rs_a;
        int                rs_b;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst, start, pad_en;
    logic [7:0]        stage_width, stage_height;
    logic [ADDR_W-1:0] base_addr;
    logic [7:0]        pixel_out, out_row, out_col;
    logic              pixel_valid, window_valid, busy, done, cfg_err;
    logic [7:0]        hist [0:129][0:129];
    vec_t              vecs [NV];
    int                n_chk = 0;
    int                n_fail = 0;

    pixel_streamer_if #(.ADDR_W(ADDR_W)) mif ();

    pixel_streamer #(.IMAGE_WIDTH(128), .IMAGE_HEIGHT(128), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stage_width  (stage_width),
        .stage_height (stage_height),
        .base_addr    (base_addr),
        .pad_en       (pad_en),
        .mem          (mif),
        .pixel_out    (pixel_out),
        .pixel_valid  (pixel_valid),
        .window_valid (window_valid),
        .out_row      (out_row),
        .out_col      (out_col),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    // Never-zero image content so that pad zeros are distinguishable.
    function automatic logic [7:0] data_of(input logic [ADDR_W-1:0] a);
        return {1'b1, a[6:0] ^ a[13:7]};
    endfunction

    always @(posedge clk) mif.mem_rdata <= mif.mem_rd_en ? data_of(mif.mem_addr) : 8'hEE;

    function automatic logic [7:0] exp_pix(input int r, input int c, input int sw, input int sh,
                                           input int w, input int pad, input int base);
        if (pad != 0 && (r == 0 || c == 0 || r == sh - 1 || c == sw - 1)) return 8'h00;
        return data_of(ADDR_W'(base + (r - pad) * w + (c - pad)));
    endfunction

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic run_frame(input int vi, input vec_t v);
        int sw, sh, n, last_t, wi, padi, bi, p, r, c, q, pr, pc;
        int n_rd, n_zero, n_win, n_done, n_err, n_frames;
        logic exp_rd, epv, ewv, ebusy, edone, eerr, prev_busy, aborted;
        logic [ADDR_W-1:0] exp_addr;
        logic [7:0] ep, er, ec;
        logic [71:0] wa, we;
        padi = v.pad ? 1 : 0;
        wi = int'(v.w);
        bi = int'(v.base);
        sw = wi + 2 * padi;
        sh = int'(v.h) + 2 * padi;
        n = v.err ? 0 : sw * sh;
        last_t = v.err ? 6 : n + 6;
        n_rd = 0; n_zero = 0; n_win = 0; n_done = 0; n_err = 0; n_frames = 0;
        prev_busy = 1'b0;
        aborted = 1'b0;
        @(negedge clk);
        stage_width = v.w; stage_height = v.h; pad_en = v.pad; base_addr = v.base;
        start = 1'b1;
        for (int t = 1; t <= last_t; t++) begin
            @(negedge clk);
            start = (t == v.rs_a) || (t == v.rs_b);
            if (v.rst_at >= 0 && t == v.rst_at + 1) begin
                chk($sformatf("v%0d reset_abort", vi),
                    72'({mif.mem_rd_en, mif.mem_addr, pixel_valid, pixel_out, window_valid,
                         out_row, out_col, busy, done, cfg_err}), 72'(0));
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            exp_rd = 1'b0; exp_addr = '0;
            if (t <= n) begin
                p = t - 1; r = p / sw; c = p % sw;
                if (!(padi != 0 && (r == 0 || c == 0 || r == sh - 1 || c == sw - 1))) begin
                    exp_rd = 1'b1;
                    exp_addr = ADDR_W'(bi + (r - padi) * wi + (c - padi));
                end
            end
            chk($sformatf("v%0d t%0d rd", vi, t), 72'({mif.mem_rd_en, mif.mem_addr}), 72'({exp_rd, exp_addr}));
            epv = 1'b0; ewv = 1'b0; ep = 8'd0; er = 8'd0; ec = 8'd0; pr = 0; pc = 0;
            if (t >= 3 && t <= n + 2) begin
                q = t - 3; pr = q / sw; pc = q % sw;
                epv = 1'b1;
                ep = exp_pix(pr, pc, sw, sh, wi, padi, bi);
                ewv = (pr >= 2) && (pc >= 2);
                if (ewv) begin er = 8'(pr - 2); ec = 8'(pc - 2); end
                hist[pr][pc] = pixel_out;
            end
            chk($sformatf("v%0d t%0d pix", vi, t), 72'({pixel_valid, pixel_out}), 72'({epv, ep}));
            chk($sformatf("v%0d t%0d win", vi, t), 72'({window_valid, out_row, out_col}), 72'({ewv, er, ec}));
            if (ewv && window_valid) begin
                wa = '0; we = '0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++) begin
                        wa = {wa[63:0], hist[pr-2+i][pc-2+j]};
                        we = {we[63:0], exp_pix(pr - 2 + i, pc - 2 + j, sw, sh, wi, padi, bi)};
                    end
                chk($sformatf("v%0d t%0d window3x3", vi, t), wa, we);
            end
            ebusy = !v.err && (t <= n + 3);
            edone = !v.err && (t == n + 3);
            eerr  = v.err && (t == 1);
            chk($sformatf("v%0d t%0d ctl", vi, t), 72'({busy, done, cfg_err}), 72'({ebusy, edone, eerr}));
            if (mif.mem_rd_en) n_rd++;
            if (pixel_valid && pixel_out == 8'd0) n_zero++;
            if (window_valid) n_win++;
            if (done) n_done++;
            if (cfg_err) n_err++;
            if (busy && !prev_busy) n_frames++;
            prev_busy = busy;
            if (t == v.rst_at) rst = 1'b1;
        end
        start = 1'b0;
        if (!aborted) begin
            chk($sformatf("v%0d reads", vi), 72'(n_rd), 72'(v.rd));
            chk($sformatf("v%0d zero_pixels", vi), 72'(n_zero), 72'(v.zero));
            chk($sformatf("v%0d windows", vi), 72'(n_win), 72'(v.win));
            chk($sformatf("v%0d done_count", vi), 72'(n_done), 72'(v.err ? 0 : 1));
            chk($sformatf("v%0d frame_count", vi), 72'(n_frames), 72'(v.err ? 0 : 1));
            chk($sformatf("v%0d cfg_err_count", vi), 72'(n_err), 72'(v.err ? 1 : 0));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; pad_en = 1'b0;
        stage_width = '0; stage_height = '0; base_addr = '0;
        //           w    h    pad   base        err   rd  zero win  rst  rsa  rsb
        vecs[0]  = '{8'd4, 8'd4, 1'b0, 14'h0100, 1'b0, 16,  0,  4,  -1,  -1,  -1};
        vecs[1]  = '{8'd4, 8'd4, 1'b1, 14'h0100, 1'b0, 16, 20, 16,  -1,  -1,  -1};
        vecs[2]  = '{8'd2, 8'd4, 1'b0, 14'h0100, 1'b1,  0,  0,  0,  -1,  -1,  -1};
        vecs[3]  = '{8'd127, 8'd4, 1'b1, 14'h0100, 1'b1, 0, 0,  0,  -1,  -1,  -1};
        vecs[4]  = '{8'd3, 8'd3, 1'b0, 14'h3FFE, 1'b0,  9,  0,  1,  -1,  -1,  -1};
        vecs[5]  = '{8'd1, 8'd1, 1'b1, 14'h0050, 1'b0,  1,  8,  1,  -1,  -1,  -1};
        vecs[6]  = '{8'd4, 8'd2, 1'b0, 14'h0100, 1'b1,  0,  0,  0,  -1,  -1,  -1};
        vecs[7]  = '{8'd0, 8'd5, 1'b1, 14'h0100, 1'b1,  0,  0,  0,  -1,  -1,  -1};
        vecs[8]  = '{8'd128, 8'd3, 1'b0, 14'h0000, 1'b0, 384, 0, 126, -1, -1,  -1};
        vecs[9]  = '{8'd5, 8'd127, 1'b1, 14'h0100, 1'b1, 0, 0,  0,  -1,  -1,  -1};
        vecs[10] = '{8'd5, 8'd5, 1'b0, 14'h0200, 1'b0, 25,  0,  9,  -1,  -1,  -1};
        vecs[11] = '{8'd5, 8'd5, 1'b1, 14'h0200, 1'b0, 25, 24, 25,  -1,  -1,  -1};
        vecs[12] = '{8'd8, 8'd8, 1'b0, 14'h0300, 1'b0,  0,  0,  0,  20,  -1,  -1};
        vecs[13] = '{8'd8, 8'd8, 1'b0, 14'h0300, 1'b0, 64,  0, 36,  -1,  -1,  -1};
        vecs[14] = '{8'd4, 8'd4, 1'b0, 14'h0100, 1'b0, 16,  0,  4,  -1,   5,  19};

        repeat (3) @(negedge clk);
        chk("reset_state",
            72'({mif.mem_rd_en, mif.mem_addr, pixel_valid, pixel_out, window_valid,
                 out_row, out_col, busy, done, cfg_err}), 72'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) run_frame(i, vecs[i]);

        // Reset and a valid start in the same cycle: reset wins.
        @(negedge clk);
        stage_width = 8'd4; stage_height = 8'd4; pad_en = 1'b0; base_addr = 14'h0100;
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_prio_a", 72'({busy, cfg_err, mif.mem_rd_en}), 72'(0));
        @(negedge clk);
        chk("rst_prio_b", 72'({busy, cfg_err, mif.mem_rd_en}), 72'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pixel_streamer.md
PIXEL_STREAMER -- requirements
Module: pixel_streamer

Interface
REQ-001 SHALL have parameters: IMAGE_WIDTH, default 128, maximum streamed row length (line-buffer depth of downstream 3x3 window collector); IMAGE_HEIGHT, default 128, maximum streamed rows; ADDR_W, default 14, memory address width.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle frame request
- stage_width  in  8  source image width, pixels
- stage_height  in  8  source image height, rows
- base_addr  in  ADDR_W  address of source pixel (0,0)
- pad_en  in  1  1 = add one-pixel zero border
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory read address
- mem_rdata  in  8  read data, valid the cycle after mem_rd_en
- pixel_out  out  8  pixel to window collector pixel_in
- pixel_valid  out  1  pixel_out is a frame pixel
- window_valid  out  1  collector window ending at pixel_out is complete
- out_row, out_col  out  8 each  output-map coordinate of that window
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after last pixel
- cfg_err  out  1  one-cycle pulse on rejected start

Function
REQ-003 SHALL stream frame in raster order, one position per cycle, no gaps, because the collector shifts every cycle.
REQ-004 Streamed size SHALL be SW x SH = stage_width x stage_height (pad_en=0) or (stage_width+2) x (stage_height+2) (pad_en=1); config latched on accepted start.
REQ-005 FSM states SHALL be IDLE, STREAM, DRAIN, DONE; IDLE->STREAM on start with valid config; STREAM->DRAIN after last streamed position issued; DRAIN->DONE when last pixel visible; DONE->IDLE unconditionally.
REQ-006 In STREAM, position (r,c) SHALL be issued in one cycle: interior position -> mem_rd_en=1, mem_addr = base_addr + src_row*stage_width + src_col (mod 2^ADDR_W); border position (pad_en=1, r or c at 0 or SW-1/SH-1) -> mem_rd_en=0, pixel forced to 0.
REQ-007 Address SHALL be formed incrementally (row base adds stage_width per row); no multiplier.
REQ-008 Position issued in cycle t SHALL appear on pixel_out/pixel_valid in cycle t+2 (registered mem_rdata or zero); pad flag and coordinates SHALL be pipelined alongside.
REQ-009 window_valid SHALL equal pixel_valid AND r>=2 AND c>=2 for the visible position; out_row=r-2, out_col=c-2 then; both coordinates 0 otherwise.
REQ-010 start SHALL be rejected with cfg_err pulse, state IDLE, when stage_width<3, stage_height<3 (pad_en=0), stage_width=0 or stage_height=0 (pad_en=1), SW>IMAGE_WIDTH, or SH>IMAGE_HEIGHT.
REQ-011 start while busy=1 SHALL be ignored, no cfg_err.
REQ-012 busy SHALL be 1 in STREAM, DRAIN, DONE; done SHALL be 1 only in DONE.
REQ-013 pixel_out SHALL be 0 whenever pixel_valid=0.
REQ-014 Integrator SHALL drive collector stage_width with SW; streamer makes no check of that wiring.

Reset
REQ-015 On rst=1 at a clock edge all state SHALL go to IDLE and every output to 0, including mid-frame; no done pulse for an aborted frame.
REQ-016 rst SHALL take priority over start in the same cycle.

Structure
REQ-017 FSM state encoding and cfg limit constants SHALL live in shared package accel_pkg.
REQ-018 Row/column position counter with wrap SHALL be one sub-module, raster_counter (outputs r, c, last).

Verification
REQ-019 4x4, pad_en=0, base 0x100, start cycle 0 -> mem_rd_en cycles 1..16 addr 0x100..0x10F; pixel_valid cycles 3..18; window_valid cycles 13,14,17,18 with (out_row,out_col)=(0,0),(0,1),(1,0),(1,1); done cycle 19.
REQ-020 4x4, pad_en=1 -> 36 streamed cycles, 16 reads, 20 zero pixels (row 0, row 5, col 0, col 5), 16 window_valid pulses covering out 0..3 x 0..3, last pixel zero.
REQ-021 stage_width=2, pad_en=0 -> cfg_err pulse, busy stays 0; stage_width=127, pad_en=1 -> cfg_err (SW=129>128).
REQ-022 rst asserted mid-frame of 8x8 -> next cycle all outputs 0, busy 0; new start runs full frame from addr base_addr.
REQ-023 start repeated during frame -> ignored, frame count and done count both 1.
REQ-024 Streamer into collector, 5x5 ramp image -> each window_valid window equals expected 3x3 neighbourhood of the ramp.
